// File: rtl/ecc_scalar_mult_core.sv
// ecc_scalar_mult_core: affine ECC scalar multiplier kP over GF(prime), sequential datapath.
// Optional feature: define ECC_CYCLE_CNT_EN to add the cycles[15:0] start-to-done counter output.
module ecc_scalar_mult_core #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] prime,
   input  logic [WIDTH-1:0] Px,
   input  logic [WIDTH-1:0] Py,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] kPx,
   output logic [WIDTH-1:0] kPy,
   output logic             done,
   output logic             busy,
   output logic             inf
`ifdef ECC_CYCLE_CNT_EN
   ,output logic [15:0]     cycles
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [2:0] {IDLE, LOAD, SCAN, DBL, ADD, FIN} state_t;
   state_t state_q, pt_next;
   logic [WIDTH-1:0] a_q, p_q, px_q, py_q, k_q, rx_q, ry_q, t0_q, t1_q, lam_q;
   logic [WIDTH-1:0] kpx_q, kpy_q, opx_q, opy_q, mx, my, x2;
   logic             rinf_q, bit_q, wait_q, done_q, busy_q, inf_q, go_q, op_inv_q, mul_ph;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       ph_q;
   logic [WIDTH-1:0] m_acc_q, m_acc_d, m_x_q, m_y_q, iv_base_q, iv_exp_q, e_res_q;
   logic [CW-1:0]    m_cnt_q, iv_cnt_q;
   logic             m_run_q, iv_run_q, iv_sq_q, e_done_q;

   function automatic logic [WIDTH-1:0] madd(input logic [WIDTH-1:0] x, y);
      logic [WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      return (s >= {1'b0, p_q}) ? WIDTH'(s - {1'b0, p_q}) : s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] msub(input logic [WIDTH-1:0] x, y);
      logic [WIDTH:0] s;
      s = {1'b0, x} - {1'b0, y};
      return (x >= y) ? s[WIDTH-1:0] : WIDTH'(s + {1'b0, p_q});
   endfunction

   function automatic logic [WIDTH-1:0] mstep(input logic [WIDTH-1:0] acc, x, input logic b);
      logic [WIDTH:0] d, s;
      d = {acc, 1'b0};
      d = (d >= {1'b0, p_q}) ? d - {1'b0, p_q} : d;
      s = b ? {1'b0, d[WIDTH-1:0]} + {1'b0, x} : {1'b0, d[WIDTH-1:0]};
      return (s >= {1'b0, p_q}) ? WIDTH'(s - {1'b0, p_q}) : s[WIDTH-1:0];
   endfunction

   // Micro-op operand selection: phases 1,7,8,9,13 use the multiplier/inverter engine
   always_comb begin
      m_acc_d = mstep(m_acc_q, m_x_q, m_y_q[WIDTH-1]);
      x2      = (state_q == ADD) ? px_q : rx_q;
      pt_next = (state_q == DBL && bit_q) ? ADD : SCAN;
      mul_ph  = ph_q == 4'd1 || ph_q == 4'd7 || ph_q == 4'd8 || ph_q == 4'd9 || ph_q == 4'd13;
      mx      = (ph_q == 4'd1) ? rx_q : (ph_q == 4'd8) ? t0_q : (ph_q == 4'd7) ? t1_q : lam_q;
      my      = (ph_q == 4'd1) ? rx_q : (ph_q == 4'd8 || ph_q == 4'd13) ? t1_q : lam_q;
   end

   // Engine: bit-serial MSB-first modmul; inversion chains square/multiply over exponent prime-2
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m_acc_q   <= '0;
         m_x_q     <= '0;
         m_y_q     <= '0;
         m_cnt_q   <= '0;
         m_run_q   <= 1'b0;
         iv_run_q  <= 1'b0;
         iv_sq_q   <= 1'b0;
         iv_base_q <= '0;
         iv_exp_q  <= '0;
         iv_cnt_q  <= '0;
         e_res_q   <= '0;
         e_done_q  <= 1'b0;
      end else begin
         e_done_q <= 1'b0;
         if (go_q) begin
            m_acc_q   <= '0;
            m_cnt_q   <= CW'(WIDTH - 1);
            m_run_q   <= 1'b1;
            iv_run_q  <= op_inv_q;
            iv_sq_q   <= 1'b1;
            iv_base_q <= opx_q;
            iv_exp_q  <= p_q - WIDTH'(2);
            iv_cnt_q  <= CW'(WIDTH - 1);
            m_x_q     <= op_inv_q ? WIDTH'(1) : opx_q;
            m_y_q     <= op_inv_q ? WIDTH'(1) : opy_q;
         end else if (m_run_q) begin
            m_acc_q <= m_acc_d;
            m_y_q   <= m_y_q << 1;
            m_cnt_q <= m_cnt_q - CW'(1);
            if (m_cnt_q == '0) begin
               m_acc_q <= '0;
               m_cnt_q <= CW'(WIDTH - 1);
               if (iv_run_q && iv_sq_q && iv_exp_q[WIDTH-1]) begin
                  m_x_q   <= m_acc_d;
                  m_y_q   <= iv_base_q;
                  iv_sq_q <= 1'b0;
               end else if (iv_run_q && iv_cnt_q != '0) begin
                  m_x_q    <= m_acc_d;
                  m_y_q    <= m_acc_d;
                  iv_sq_q  <= 1'b1;
                  iv_cnt_q <= iv_cnt_q - CW'(1);
                  iv_exp_q <= iv_exp_q << 1;
               end else begin
                  e_res_q  <= m_acc_d;
                  e_done_q <= 1'b1;
                  m_run_q  <= 1'b0;
                  iv_run_q <= 1'b0;
               end
            end
         end
      end
   end

   // Main FSM: double-and-add scan with micro-phased point doubling/addition
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         p_q      <= '0;
         px_q     <= '0;
         py_q     <= '0;
         k_q      <= '0;
         rx_q     <= '0;
         ry_q     <= '0;
         t0_q     <= '0;
         t1_q     <= '0;
         lam_q    <= '0;
         kpx_q    <= '0;
         kpy_q    <= '0;
         opx_q    <= '0;
         opy_q    <= '0;
         rinf_q   <= 1'b0;
         bit_q    <= 1'b0;
         wait_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         inf_q    <= 1'b0;
         go_q     <= 1'b0;
         op_inv_q <= 1'b0;
         cnt_q    <= '0;
         ph_q     <= '0;
      end else begin
         go_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (i_start) begin
               a_q     <= a;
               p_q     <= prime;
               px_q    <= Px;
               py_q    <= Py;
               k_q     <= k;
               busy_q  <= 1'b1;
               state_q <= LOAD;
            end
            LOAD: begin
               rinf_q  <= 1'b1;
               rx_q    <= '0;
               ry_q    <= '0;
               cnt_q   <= CW'(WIDTH);
               ph_q    <= '0;
               wait_q  <= 1'b0;
               state_q <= (k_q == '0) ? FIN : SCAN;
            end
            SCAN: if (cnt_q == '0) state_q <= FIN;
            else begin
               cnt_q   <= cnt_q - CW'(1);
               bit_q   <= k_q[WIDTH-1];
               k_q     <= k_q << 1;
               ph_q    <= '0;
               state_q <= DBL;
            end
            DBL, ADD: if (mul_ph) begin
               if (!wait_q) begin
                  go_q     <= 1'b1;
                  op_inv_q <= ph_q == 4'd7;
                  opx_q    <= mx;
                  opy_q    <= my;
                  wait_q   <= 1'b1;
               end else if (e_done_q) begin
                  wait_q <= 1'b0;
                  ph_q   <= ph_q + 4'd1;
                  if (ph_q == 4'd8) lam_q <= e_res_q;
                  else if (ph_q == 4'd7 || ph_q == 4'd13) t1_q <= e_res_q;
                  else t0_q <= e_res_q;
               end
            end else begin
               ph_q <= ph_q + 4'd1;
               case (ph_q)
                  4'd0: if (state_q == DBL) begin
                     if (rinf_q || ry_q == '0) begin
                        rinf_q  <= 1'b1;
                        ph_q    <= '0;
                        state_q <= pt_next;
                     end
                  end else if (rinf_q) begin
                     rx_q    <= px_q;
                     ry_q    <= py_q;
                     rinf_q  <= 1'b0;
                     ph_q    <= '0;
                     state_q <= SCAN;
                  end else if (rx_q != px_q) ph_q <= 4'd6;
                  else if (ry_q != py_q || ry_q == '0) begin
                     rinf_q  <= 1'b1;
                     ph_q    <= '0;
                     state_q <= SCAN;
                  end
                  4'd2: t1_q <= madd(t0_q, t0_q);
                  4'd3: t0_q <= madd(t1_q, t0_q);
                  4'd4: t0_q <= madd(t0_q, a_q);
                  4'd5: begin
                     t1_q <= madd(ry_q, ry_q);
                     ph_q <= 4'd7;
                  end
                  4'd6: begin
                     t0_q <= msub(py_q, ry_q);
                     t1_q <= msub(px_q, rx_q);
                  end
                  4'd10: t0_q <= msub(t0_q, rx_q);
                  4'd11: t0_q <= msub(t0_q, x2);
                  4'd12: t1_q <= msub(rx_q, t0_q);
                  4'd14: begin
                     rx_q    <= t0_q;
                     ry_q    <= msub(t1_q, ry_q);
                     rinf_q  <= 1'b0;
                     ph_q    <= '0;
                     state_q <= pt_next;
                  end
                  default: ;
               endcase
            end
            FIN: begin
               kpx_q   <= rinf_q ? '0 : rx_q;
               kpy_q   <= rinf_q ? '0 : ry_q;
               inf_q   <= rinf_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ECC_CYCLE_CNT_EN
   logic [15:0] run_q, cyc_q, run_inc;

   assign run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

   // Saturating start-to-done cycle count, published when the result is issued
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         run_q <= '0;
         cyc_q <= '0;
      end else begin
         if (state_q == IDLE && i_start) run_q <= 16'd1;
         else if (busy_q) run_q <= run_inc;
         if (state_q == FIN) cyc_q <= run_inc;
      end
   end

   assign cycles = cyc_q;
`endif

   assign kPx  = kpx_q;
   assign kPy  = kpy_q;
   assign done = done_q;
   assign busy = busy_q;
   assign inf  = inf_q;
endmodule

// File: tb/tb_ecc_scalar_mult_core.sv
// tb_ecc_scalar_mult_core: directed checks on curve a=2, prime=17, P=(5,1), order 19.
module tb_ecc_scalar_mult_core;
   localparam int LIMIT = 20000;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0] a = 8'd2, prime = 8'd17, px = 8'd5, py = 8'd1, k = 8'd0;
   logic [7:0] kpx, kpy;
   logic       done, busy, inf;
`ifdef ECC_CYCLE_CNT_EN
   logic [15:0] cycles;
`endif
   int checks = 0, failures = 0;

   ecc_scalar_mult_core #(.WIDTH(8)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_start(start), .a(a), .prime(prime),
      .Px(px), .Py(py), .k(k), .kPx(kpx), .kPy(kpy), .done(done), .busy(busy), .inf(inf)
`ifdef ECC_CYCLE_CNT_EN
      , .cycles(cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic run_op(input logic [7:0] kk, output int lat);
      @(negedge clk);
      k = kk;
      start = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
      end while (!done && lat < LIMIT);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (kpx !== 8'd0) begin failures++; $display("FAIL reset_kPx got=%0d exp=0", kpx); end
      checks++; if (kpy !== 8'd0) begin failures++; $display("FAIL reset_kPy got=%0d exp=0", kpy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (inf !== 1'b0) begin failures++; $display("FAIL reset_inf got=%b exp=0", inf); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      int lat, pulses;
      run_op(8'd1, lat);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL k1_timeout got=%b exp=1 after %0d cycles", done, lat); end
      checks++; if (kpx !== 8'd5) begin failures++; $display("FAIL k1_x got=%0d exp=5", kpx); end
      checks++; if (kpy !== 8'd1) begin failures++; $display("FAIL k1_y got=%0d exp=1", kpy); end
      checks++; if (inf !== 1'b0) begin failures++; $display("FAIL k1_inf got=%b exp=0", inf); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL k1_busy_at_done got=%b exp=0", busy); end
      pulses = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checks++; if (pulses != 0) begin failures++; $display("FAIL k1_extra_done got=%0d exp=0", pulses); end
      checks++; if (kpx !== 8'd5 || kpy !== 8'd1) begin failures++; $display("FAIL k1_hold got=(%0d,%0d) exp=(5,1)", kpx, kpy); end
   endtask

   task automatic test_multiples;
      logic [7:0] ks [4] = '{8'd2, 8'd9, 8'd10, 8'd20};
      logic [7:0] ex [4] = '{8'd6, 8'd7, 8'd7, 8'd5};
      logic [7:0] ey [4] = '{8'd3, 8'd6, 8'd11, 8'd1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ks[i], lat);
         checks++; if (kpx !== ex[i] || kpy !== ey[i] || inf !== 1'b0 || done !== 1'b1)
            begin failures++; $display("FAIL mult_k%0d got=(%0d,%0d) inf=%b done=%b exp=(%0d,%0d) inf=0 done=1", ks[i], kpx, kpy, inf, done, ex[i], ey[i]); end
      end
   endtask

   task automatic test_infinity;
      int lat;
      run_op(8'd0, lat);
      checks++; if (lat != 3 || done !== 1'b1) begin failures++; $display("FAIL k0_latency got=%0d exp=3", lat); end
      checks++; if (inf !== 1'b1 || kpx !== 8'd0 || kpy !== 8'd0) begin failures++; $display("FAIL k0_inf got=%b (%0d,%0d) exp=1 (0,0)", inf, kpx, kpy); end
      run_op(8'd2, lat);
      checks++; if (inf !== 1'b0 || kpx !== 8'd6) begin failures++; $display("FAIL k2_clear got=%b x=%0d exp=0 x=6", inf, kpx); end
      run_op(8'd19, lat);
      checks++; if (inf !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL k19_inf got=%b exp=1", inf); end
      checks++; if (kpx !== 8'd0 || kpy !== 8'd0) begin failures++; $display("FAIL k19_xy got=(%0d,%0d) exp=(0,0)", kpx, kpy); end
   endtask

   task automatic test_busy_ignore;
      int lat;
      @(negedge clk);
      k = 8'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", busy); end
      repeat (5) @(posedge clk);
      @(negedge clk);
      k = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (kpx !== 8'd7 || kpy !== 8'd6 || done !== 1'b1) begin failures++; $display("FAIL busy_ignore got=(%0d,%0d) done=%b exp=(7,6) done=1", kpx, kpy, done); end
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_ignore_restart got=%b exp=0", busy); end
   endtask

   task automatic test_abort;
      int seen, lat;
      seen = 0;
      @(negedge clk);
      k = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (250) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (kpx !== 8'd0 || kpy !== 8'd0) begin failures++; $display("FAIL abort_xy got=(%0d,%0d) exp=(0,0)", kpx, kpy); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
      run_op(8'd3, lat);
      checks++; if (kpx !== 8'd10 || kpy !== 8'd6 || inf !== 1'b0) begin failures++; $display("FAIL abort_k3 got=(%0d,%0d) inf=%b exp=(10,6) inf=0", kpx, kpy, inf); end
   endtask

`ifdef ECC_CYCLE_CNT_EN
   task automatic test_cycle_count;
      int lat;
      run_op(8'd9, lat);
      checks++; if (cycles !== 16'(lat)) begin failures++; $display("FAIL cycles_k9 got=%0d exp=%0d", cycles, lat); end
      run_op(8'd0, lat);
      checks++; if (cycles !== 16'd3) begin failures++; $display("FAIL cycles_k0 got=%0d exp=3", cycles); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multiples();
      test_infinity();
      test_busy_ignore();
      test_abort();
`ifdef ECC_CYCLE_CNT_EN
      test_cycle_count();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
